vfd_scanout: RTL and testbench

Reads the composited VFD frame out of VRAM and turns it into a 640×480 60 Hz raster for the video output path. The compositor writes 8-bit RGB332 pixels linearly at addresses 0..307199. This block is the consumer on the other port of that VRAM. It generates sync and blank timing, fetches one byte per pixel, expands it to 24-bit RGB and aligns it with the sync signals.

---
 rtl/vfd_pkg.sv | 27 ++
 rtl/vfd_video_timing.sv | 70 +++++++
 rtl/vfd_scanout.sv | 139 +++++++++++++
 tb/tb_vfd_scanout.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/vfd_pkg.sv
// Shared VFD constants: 640x480@60 timing defaults, frame-buffer geometry and
// the RGB332 -> RGB888 expansion used by the scanout.
package vfd_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int FB_PIXELS = H_ACTIVE * V_ACTIVE;
  localparam int FB_ADDR_W = 19;

  // Bit replication spreads each channel over the full 0..255 range.
  function automatic logic [23:0] rgb332_expand(input logic [7:0] p);
    return {p[7:5], p[7:5], p[7:6],
            p[4:2], p[4:2], p[4:3],
            {4{p[1:0]}}};
  endfunction

endpackage

// File: rtl/vfd_video_timing.sv
// Raster counters (hc/vc) and the raw, unpipelined sync/blank/active decode.
module vfd_video_timing #(
  parameter int H_ACTIVE = vfd_pkg::H_ACTIVE,
  parameter int H_FP     = vfd_pkg::H_FP,
  parameter int H_SYNC   = vfd_pkg::H_SYNC,
  parameter int H_BP     = vfd_pkg::H_BP,
  parameter int V_ACTIVE = vfd_pkg::V_ACTIVE,
  parameter int V_FP     = vfd_pkg::V_FP,
  parameter int V_SYNC   = vfd_pkg::V_SYNC,
  parameter int V_BP     = vfd_pkg::V_BP
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ce_pix_i,
  output logic active_o,
  output logic hsync_n_o,
  output logic vsync_n_o,
  output logic hblank_o,
  output logic vblank_o,
  output logic origin_o
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HC_W  = $clog2(H_TOT);
  localparam int VC_W  = $clog2(V_TOT);

  localparam logic [HC_W-1:0] HC_LAST = HC_W'(H_TOT - 1);
  localparam logic [HC_W-1:0] HC_ACT  = HC_W'(H_ACTIVE);
  localparam logic [HC_W-1:0] HS_BEG  = HC_W'(H_ACTIVE + H_FP);
  localparam logic [HC_W-1:0] HS_END  = HC_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VC_W-1:0] VC_LAST = VC_W'(V_TOT - 1);
  localparam logic [VC_W-1:0] VC_ACT  = VC_W'(V_ACTIVE);
  localparam logic [VC_W-1:0] VS_BEG  = VC_W'(V_ACTIVE + V_FP);
  localparam logic [VC_W-1:0] VS_END  = VC_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [HC_W-1:0] hc_q, hc_d;
  logic [VC_W-1:0] vc_q, vc_d;

  always_comb begin
    hc_d = hc_q;
    vc_d = vc_q;
    if (ce_pix_i) begin
      if (hc_q == HC_LAST) begin
        hc_d = '0;
        vc_d = (vc_q == VC_LAST) ? '0 : vc_q + 1'b1;
      end else begin
        hc_d = hc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hc_q <= '0;
      vc_q <= '0;
    end else begin
      hc_q <= hc_d;
      vc_q <= vc_d;
    end
  end

  assign hblank_o  = (hc_q >= HC_ACT);
  assign vblank_o  = (vc_q >= VC_ACT);
  assign active_o  = !hblank_o && !vblank_o;
  assign hsync_n_o = !((hc_q >= HS_BEG) && (hc_q < HS_END));
  assign vsync_n_o = !((vc_q >= VS_BEG) && (vc_q < VS_END));
  assign origin_o  = (hc_q == '0) && (vc_q == '0);

endmodule

// File: rtl/vfd_scanout.sv
// VRAM scanout: address pointer and fetch (stage 0), RGB332 expansion and
// sync/blank alignment (stage 1). Outputs trail the counters by 2 ce_pix.
module vfd_scanout #(
  parameter int H_ACTIVE = vfd_pkg::H_ACTIVE,
  parameter int H_FP     = vfd_pkg::H_FP,
  parameter int H_SYNC   = vfd_pkg::H_SYNC,
  parameter int H_BP     = vfd_pkg::H_BP,
  parameter int V_ACTIVE = vfd_pkg::V_ACTIVE,
  parameter int V_FP     = vfd_pkg::V_FP,
  parameter int V_SYNC   = vfd_pkg::V_SYNC,
  parameter int V_BP     = vfd_pkg::V_BP
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ce_pix,
  input  logic                          enable,
  output logic [vfd_pkg::FB_ADDR_W-1:0] vram_addr,
  output logic                          vram_rd,
  input  logic [7:0]                    vram_data,
  output logic [7:0]                    r,
  output logic [7:0]                    g,
  output logic [7:0]                    b,
  output logic                          hsync,
  output logic                          vsync,
  output logic                          hblank,
  output logic                          vblank,
  output logic                          de,
  output logic                          frame_start
);
  import vfd_pkg::*;

  localparam int AW = FB_ADDR_W;
  localparam logic [AW-1:0] PIX_LAST = AW'(H_ACTIVE * V_ACTIVE - 1);

  logic active, hsync_n_raw, vsync_n_raw, hblank_raw, vblank_raw, origin;

  vfd_video_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk       (clk),
    .rst_n     (rst_n),
    .ce_pix_i  (ce_pix),
    .active_o  (active),
    .hsync_n_o (hsync_n_raw),
    .vsync_n_o (vsync_n_raw),
    .hblank_o  (hblank_raw),
    .vblank_o  (vblank_raw),
    .origin_o  (origin)
  );

  logic          frame_en_q, frame_en_d;
  logic [AW-1:0] ptr_q, ptr_d, ptr_cur;
  logic [AW-1:0] addr_q, addr_d;
  logic          rd_q, rd_d;
  logic          fetch;

  // At the frame origin the fresh enable and a zeroed pointer are used
  // directly, so the first pixel of the frame already obeys the new flag.
  always_comb begin
    ptr_cur    = origin ? '0 : ptr_q;
    fetch      = active && (origin ? enable : frame_en_q);
    frame_en_d = frame_en_q;
    ptr_d      = ptr_q;
    addr_d     = addr_q;
    rd_d       = rd_q;
    if (ce_pix) begin
      rd_d = fetch;
      if (origin) begin
        frame_en_d = enable;
        ptr_d      = '0;
      end
      if (fetch) begin
        addr_d = ptr_cur;
        ptr_d  = (ptr_cur == PIX_LAST) ? ptr_cur : ptr_cur + 1'b1;
      end
    end
  end

  logic        hsync1_q, vsync1_q, hblank1_q, vblank1_q, de1_q, fs1_q, fetched1_q;
  logic        hsync_q, vsync_q, hblank_q, vblank_q, de_q, fs_q;
  logic [23:0] rgb_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_en_q <= 1'b0;
      ptr_q      <= '0;
      addr_q     <= '0;
      rd_q       <= 1'b0;
      hsync1_q   <= 1'b1;
      vsync1_q   <= 1'b1;
      hblank1_q  <= 1'b1;
      vblank1_q  <= 1'b1;
      de1_q      <= 1'b0;
      fs1_q      <= 1'b0;
      fetched1_q <= 1'b0;
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
      hblank_q   <= 1'b1;
      vblank_q   <= 1'b1;
      de_q       <= 1'b0;
      fs_q       <= 1'b0;
      rgb_q      <= '0;
    end else begin
      frame_en_q <= frame_en_d;
      ptr_q      <= ptr_d;
      addr_q     <= addr_d;
      rd_q       <= rd_d;
      if (ce_pix) begin
        hsync1_q   <= hsync_n_raw;
        vsync1_q   <= vsync_n_raw;
        hblank1_q  <= hblank_raw;
        vblank1_q  <= vblank_raw;
        de1_q      <= active;
        fs1_q      <= origin;
        fetched1_q <= fetch;
        hsync_q    <= hsync1_q;
        vsync_q    <= vsync1_q;
        hblank_q   <= hblank1_q;
        vblank_q   <= vblank1_q;
        de_q       <= de1_q;
        fs_q       <= fs1_q;
        // Only pixels actually fetched carry colour; blanking and disabled frames are black.
        rgb_q      <= (de1_q && fetched1_q) ? rgb332_expand(vram_data) : '0;
      end
    end
  end

  assign vram_addr   = addr_q;
  assign vram_rd     = rd_q;
  assign {r, g, b}   = rgb_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign hblank      = hblank_q;
  assign vblank      = vblank_q;
  assign de          = de_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vfd_scanout.sv
// Self-checking bench for vfd_scanout on a scaled-down raster, compared
// against a position-arithmetic model of the expected raster.
module tb_vfd_scanout;

  localparam int HA = 32, HFP = 2, HSW = 4, HBP = 2;
  localparam int VA = 10, VFP = 2, VSW = 2, VBP = 3;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int FRAME = HT * VT;
  localparam int NPIX = HA * VA;
  localparam logic [31:0] RST_VEC = {1'b0, 24'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  logic        clk = 1'b0;
  logic        rst_n, ce_pix, enable;
  logic [18:0] vram_addr;
  logic        vram_rd;
  logic [7:0]  vram_data, r, g, b;
  logic        hsync, vsync, hblank, vblank, de, frame_start;

  int checks = 0, failures = 0;
  int k = 0;
  bit fen [0:15];
  int reads [0:15];
  int max_addr, hs_low, vs_low, hs_first, fs_first;
  bit stats_on;
  logic [23:0] rgb_ff, rgb_e0;

  always #5 clk = ~clk;

  // VRAM returns the low address byte one clock after the registered read.
  assign vram_data = vram_rd ? vram_addr[7:0] : 8'hA5;

  vfd_scanout #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ce_pix(ce_pix), .enable(enable),
    .vram_addr(vram_addr), .vram_rd(vram_rd), .vram_data(vram_data),
    .r(r), .g(g), .b(b), .hsync(hsync), .vsync(vsync),
    .hblank(hblank), .vblank(vblank), .de(de), .frame_start(frame_start)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  function automatic logic [23:0] ref_rgb(input int idx);
    int p, r3, g3, b2, rr, gg, bb;
    p  = idx % 256;
    r3 = p / 32;
    g3 = (p / 4) % 8;
    b2 = p % 4;
    rr = r3 * 32 + r3 * 4 + r3 / 2;
    gg = g3 * 32 + g3 * 4 + g3 / 2;
    bb = b2 * 85;
    return {rr[7:0], gg[7:0], bb[7:0]};
  endfunction

  function automatic logic [31:0] obs_vec();
    return {1'b0, r, g, b, hsync, vsync, hblank, vblank, de, frame_start, vram_rd};
  endfunction

  // Output after ce edge k shows raster position k-2; the fetch strobe shows k-1.
  function automatic logic [31:0] exp_vec();
    int s, f, x, y;
    bit hs, vs, hb, vb, de_e, fs_e, rd_e;
    logic [23:0] rgb;
    rgb = '0; hs = 1; vs = 1; hb = 1; vb = 1; de_e = 0; fs_e = 0; rd_e = 0;
    if (k >= 2) begin
      s = (k - 2) % FRAME; f = (k - 2) / FRAME;
      x = s % HT; y = s / HT;
      hs   = !(x >= HA + HFP && x < HA + HFP + HSW);
      vs   = !(y >= VA + VFP && y < VA + VFP + VSW);
      hb   = x >= HA;
      vb   = y >= VA;
      de_e = !hb && !vb;
      fs_e = (s == 0);
      rgb  = (de_e && fen[f]) ? ref_rgb(y * HA + x) : 24'h0;
    end
    if (k >= 1) begin
      s = (k - 1) % FRAME; f = (k - 1) / FRAME;
      x = s % HT; y = s / HT;
      rd_e = (x < HA) && (y < VA) && fen[f];
    end
    return {1'b0, rgb, hs, vs, hb, vb, de_e, fs_e, rd_e};
  endfunction

  task automatic tick(input bit ce);
    int q, x, y;
    ce_pix = ce;
    if (ce && (k % FRAME) == 0) fen[k / FRAME] = enable;
    @(posedge clk);
    #1;
    if (ce) begin
      k++;
      q = (k - 1) % FRAME; x = q % HT; y = q / HT;
      if (vram_rd) begin
        reads[(k - 1) / FRAME]++;
        if (int'(vram_addr) > max_addr) max_addr = int'(vram_addr);
        chk("vram_addr", {13'h0, vram_addr}, y * HA + x);
      end
      if (stats_on && k >= 2 && (k - 2) / FRAME == 0) begin
        q = k - 2; x = q % HT; y = q / HT;
        if (!hsync) begin
          hs_low++;
          if (hs_first < 0) hs_first = x;
        end
        if (!vsync) vs_low++;
        if (x < HA && y < VA && y * HA + x == 255) rgb_ff = {r, g, b};
        if (x < HA && y < VA && y * HA + x == 224) rgb_e0 = {r, g, b};
      end
      if (frame_start && fs_first < 0) fs_first = k;
    end
    chk("outputs", obs_vec(), exp_vec());
  endtask

  task automatic clear_model();
    k = 0;
    foreach (fen[i]) fen[i] = 1'b0;
    foreach (reads[i]) reads[i] = 0;
    fs_first = -1;
  endtask

  initial begin
    clear_model();
    max_addr = -1; hs_low = 0; vs_low = 0; hs_first = -1;
    stats_on = 0; rgb_ff = '0; rgb_e0 = '0;
    enable = 1'b1; ce_pix = 1'b1; rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_vec", obs_vec(), RST_VEC);
    chk("reset_addr", {13'h0, vram_addr}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Frozen with ce_pix low, then two full frames at 1:1.
    tick(0); tick(0);
    stats_on = 1;
    while (k < 2 * FRAME) tick(1);
    stats_on = 0;
    chk("frame0_reads", reads[0], NPIX);
    chk("frame1_reads", reads[1], NPIX);
    chk("max_addr", max_addr, NPIX - 1);
    chk("hsync_low_count", hs_low, HSW * VT);
    chk("hsync_start_x", hs_first, HA + HFP);
    chk("vsync_low_count", vs_low, VSW * HT);
    chk("rgb_of_ff", rgb_ff, 24'hFFFFFF);
    chk("rgb_of_e0", rgb_e0, 24'hFF0000);
    chk("first_frame_start_k", fs_first, 2);

    // Drop enable mid-frame: current frame intact, next frame dark.
    while (k < 3 * FRAME) begin
      if (k == 2 * FRAME + (VA / 2) * HT) enable = 1'b0;
      tick(1);
    end
    while (k < 4 * FRAME) begin
      if (k == 3 * FRAME + VA * HT) enable = 1'b1;
      tick(1);
    end

    // One frame with ce_pix every 4th clock; idle clocks must hold outputs.
    while (k < 5 * FRAME + 2) begin
      tick(1); tick(0); tick(0); tick(0);
    end
    chk("frame2_reads", reads[2], NPIX);
    chk("frame3_reads_disabled", reads[3], 0);
    chk("frame4_reads_ce4", reads[4], NPIX);

    // Asynchronous reset in the middle of a line.
    while (k < 5 * FRAME + 3 * HT + 15) tick(1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset_vec", obs_vec(), RST_VEC);
    chk("async_reset_addr", {13'h0, vram_addr}, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_hold_vec", obs_vec(), RST_VEC);
    @(negedge clk);
    rst_n = 1'b1;
    clear_model();
    while (k < FRAME + 2) tick(1);
    chk("restart_frame_start_k", fs_first, 2);
    chk("restart_reads", reads[0], NPIX);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
